// File: rtl/fetch_controller.sv
// ============================================================================
// fetch_controller : instruction fetch FSM with a one-entry output register,
//                    back-pressure stall, branch redirect and bounds fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_controller #(
   parameter int IMEM_DEPTH = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [31:0] i_start_pc,
   output logic        o_imem_en,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_br_valid,
   input  logic [31:0] i_br_target,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_instr,
   output logic [31:0] o_out_pc,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic [15:0] o_xfer_count
);

   localparam logic [31:0] c_DEPTH = 32'(IMEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_STALL = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_pc_jumped;
   logic        r_out_valid;
   logic [31:0] r_out_instr;
   logic [31:0] r_out_pc;
   logic [15:0] r_xfer_count;

   logic w_xfer;
   logic w_slot_free;
   logic w_pc_legal;
   logic w_read;

   assign w_xfer      = r_out_valid & i_out_ready;
   assign w_slot_free = ~r_out_valid | i_out_ready;
   assign w_pc_legal  = (r_pc < c_DEPTH);
   assign w_read      = (r_state == S_FETCH) & ~i_br_valid & w_slot_free & w_pc_legal;

   // r_pc_jumped marks a pc loaded from start_pc/br_target, so running off the
   // end of memory sequentially is DONE while jumping out of range is FAULT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_pc         <= 32'd0;
         r_pc_jumped  <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_instr  <= 32'd0;
         r_out_pc     <= 32'd0;
         r_xfer_count <= 16'd0;
      end else begin
         if (w_xfer) begin
            r_xfer_count <= r_xfer_count + 16'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_pc         <= i_start_pc;
                  r_pc_jumped  <= 1'b1;
                  r_xfer_count <= 16'd0;
                  r_state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (i_br_valid) begin
                  r_pc        <= i_br_target;
                  r_pc_jumped <= 1'b1;
                  r_out_valid <= 1'b0;
               end else if (!w_slot_free) begin
                  r_state <= S_STALL;
               end else if (!w_pc_legal) begin
                  r_out_valid <= 1'b0;
                  r_state     <= r_pc_jumped ? S_FAULT : S_DONE;
               end else begin
                  r_out_instr <= i_imem_rdata;
                  r_out_pc    <= r_pc;
                  r_out_valid <= 1'b1;
                  r_pc        <= r_pc + 32'd1;
                  r_pc_jumped <= 1'b0;
               end
            end
            S_STALL: begin
               if (i_br_valid) begin
                  r_pc        <= i_br_target;
                  r_pc_jumped <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_state     <= S_FETCH;
               end else if (w_xfer) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_FETCH;
               end
            end
            S_DONE, S_FAULT: begin
               // A restart discards whatever is still waiting in the output slot.
               if (i_start) begin
                  r_pc         <= i_start_pc;
                  r_pc_jumped  <= 1'b1;
                  r_xfer_count <= 16'd0;
                  r_out_valid  <= 1'b0;
                  r_state      <= S_FETCH;
               end else if (w_xfer) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_imem_en    = w_read;
   assign o_imem_addr  = w_read ? r_pc : 32'd0;
   assign o_out_valid  = r_out_valid;
   assign o_out_instr  = r_out_instr;
   assign o_out_pc     = r_out_pc;
   assign o_xfer_count = r_xfer_count;
   assign o_done       = (r_state == S_DONE);
   assign o_fault      = (r_state == S_FAULT);
   assign o_busy       = (r_state == S_FETCH) | (r_state == S_STALL) |
                         (((r_state == S_DONE) | (r_state == S_FAULT)) & r_out_valid);

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// tb_fetch_controller : directed scenarios for fetch_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_controller;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] start_pc;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        br_valid;
   logic [31:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        busy;
   logic        done;
   logic        fault;
   logic [15:0] xfer_count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_controller #(.IMEM_DEPTH(13)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start),
      .i_start_pc   (start_pc),
      .o_imem_en    (imem_en),
      .o_imem_addr  (imem_addr),
      .i_imem_rdata (imem_rdata),
      .i_br_valid   (br_valid),
      .i_br_target  (br_target),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_instr  (out_instr),
      .o_out_pc     (out_pc),
      .o_busy       (busy),
      .o_done       (done),
      .o_fault      (fault),
      .o_xfer_count (xfer_count)
   );

   // Word i of the memory holds 0xE000_0000 + i.
   assign imem_rdata = 32'hE000_0000 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_done(input logic [15:0] exp_count);
      for (int k = 0; k < 60 && !done; k++) @(negedge clk);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: done=%b required 1", done);
      end
      n_checks++;
      if (xfer_count !== exp_count) begin
         n_fail++;
         $display("FAIL done_count: xfer_count=%0d required %0d", xfer_count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({out_valid, imem_en, busy, done, fault} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: {v,en,busy,done,fault}=%b required 00000",
                  {out_valid, imem_en, busy, done, fault});
      end
      n_checks++;
      if ({imem_addr, out_instr, out_pc, xfer_count} !== 112'd0) begin
         n_fail++;
         $display("FAIL reset_data: addr=%h instr=%h pc=%h count=%h required all 0",
                  imem_addr, out_instr, out_pc, xfer_count);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_en !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_fetch: en=%b busy=%b required 0 0", imem_en, busy);
      end
   endtask

   task automatic test_sequential();
      start = 1'b1; start_pc = 32'd0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (imem_en !== 1'b1 || imem_addr !== 32'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_first_read: en=%b addr=%h v=%b required 1 0 0",
                  imem_en, imem_addr, out_valid);
      end
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, out_instr, out_pc} !== {1'b1, 32'hE000_0000 + 32'(i), 32'(i)}) begin
            n_fail++;
            $display("FAIL seq_word%0d: v=%b instr=%h pc=%0d required 1 %h %0d",
                     i, out_valid, out_instr, out_pc, 32'hE000_0000 + 32'(i), i);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({done, busy, out_valid, fault} !== 4'b1000 || xfer_count !== 16'd13) begin
         n_fail++;
         $display("FAIL seq_done: done=%b busy=%b v=%b fault=%b count=%0d required 1 0 0 0 13",
                  done, busy, out_valid, fault, xfer_count);
      end
   endtask

   task automatic test_stall();
      start = 1'b1; start_pc = 32'd2; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'd2) begin
         n_fail++;
         $display("FAIL stall_first_read: done=%b en=%b addr=%h required 0 1 2",
                  done, imem_en, imem_addr);
      end
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         n_checks++;
         if ({out_valid, out_instr, out_pc, imem_en} !== {1'b1, 32'hE000_0002, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: v=%b instr=%h pc=%0d en=%b required 1 e0000002 2 0",
                     h, out_valid, out_instr, out_pc, imem_en);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'd3 || xfer_count !== 16'd1) begin
         n_fail++;
         $display("FAIL stall_bubble: v=%b en=%b addr=%h count=%0d required 0 1 3 1",
                  out_valid, imem_en, imem_addr, xfer_count);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'hE000_0003 || out_pc !== 32'd3) begin
         n_fail++;
         $display("FAIL stall_resume: v=%b instr=%h pc=%0d required 1 e0000003 3",
                  out_valid, out_instr, out_pc);
      end
      wait_done(16'd11);
   endtask

   task automatic test_branch_drop();
      start = 1'b1; start_pc = 32'd0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (out_pc !== 32'd4 || out_valid !== 1'b1 || xfer_count !== 16'd4) begin
         n_fail++;
         $display("FAIL br_at4: pc=%0d v=%b count=%0d required 4 1 4", out_pc, out_valid, xfer_count);
      end
      out_ready = 1'b0; br_valid = 1'b1; br_target = 32'd10;
      #1;
      n_checks++;
      if (imem_en !== 1'b0) begin
         n_fail++;
         $display("FAIL br_no_read: en=%b required 0", imem_en);
      end
      @(negedge clk);
      br_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || xfer_count !== 16'd4 || imem_en !== 1'b1 || imem_addr !== 32'd10) begin
         n_fail++;
         $display("FAIL br_redirect: v=%b count=%0d en=%b addr=%0d required 0 4 1 10",
                  out_valid, xfer_count, imem_en, imem_addr);
      end
      @(negedge clk);
      n_checks++;
      if (out_pc !== 32'd10 || out_instr !== 32'hE000_000A || xfer_count !== 16'd4) begin
         n_fail++;
         $display("FAIL br_target_word: pc=%0d instr=%h count=%0d required 10 e000000a 4",
                  out_pc, out_instr, xfer_count);
      end
      wait_done(16'd7);
   endtask

   task automatic test_branch_fault();
      start = 1'b1; start_pc = 32'd0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      br_valid = 1'b1; br_target = 32'd20;
      @(negedge clk);
      br_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || imem_en !== 1'b0 || xfer_count !== 16'd1 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_redirect: v=%b en=%b count=%0d fault=%b required 0 0 1 0",
                  out_valid, imem_en, xfer_count, fault);
      end
      @(negedge clk);
      n_checks++;
      if ({fault, done, imem_en, out_valid, busy} !== 5'b10000) begin
         n_fail++;
         $display("FAIL fault_state: {fault,done,en,v,busy}=%b required 10000",
                  {fault, done, imem_en, out_valid, busy});
      end
      br_valid = 1'b1; br_target = 32'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || imem_en !== 1'b0 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_hold%0d: v=%b en=%b fault=%b required 0 0 1",
                     k, out_valid, imem_en, fault);
         end
      end
      br_valid = 1'b0;
      start = 1'b1; start_pc = 32'd0;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (fault !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'd0 || xfer_count !== 16'd0) begin
         n_fail++;
         $display("FAIL fault_restart: fault=%b en=%b addr=%0d count=%0d required 0 1 0 0",
                  fault, imem_en, imem_addr, xfer_count);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'hE000_0000) begin
         n_fail++;
         $display("FAIL fault_resume: v=%b pc=%0d instr=%h required 1 0 e0000000",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_instr !== 32'hE000_0000) begin
         n_fail++;
         $display("FAIL mid_stalled: v=%b busy=%b instr=%h required 1 1 e0000000",
                  out_valid, busy, out_instr);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if ({out_valid, imem_en, busy, done, fault} !== 5'b0 ||
          {imem_addr, out_instr, out_pc, xfer_count} !== 112'd0) begin
         n_fail++;
         $display("FAIL mid_reset: flags=%b addr=%h instr=%h pc=%h count=%h required all 0",
                  {out_valid, imem_en, busy, done, fault}, imem_addr, out_instr, out_pc, xfer_count);
      end
      br_valid = 1'b1; br_target = 32'd3; out_ready = 1'b1;
      @(negedge clk);
      br_valid = 1'b0;
      n_checks++;
      if (imem_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_idle: en=%b v=%b busy=%b required 0 0 0", imem_en, out_valid, busy);
      end
      start = 1'b1; start_pc = 32'd5;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (imem_en !== 1'b1 || imem_addr !== 32'd5) begin
         n_fail++;
         $display("FAIL mid_restart_read: en=%b addr=%0d required 1 5", imem_en, imem_addr);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd5 || out_instr !== 32'hE000_0005) begin
         n_fail++;
         $display("FAIL mid_restart_word: v=%b pc=%0d instr=%h required 1 5 e0000005",
                  out_valid, out_pc, out_instr);
      end
      wait_done(16'd8);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_pc = 32'd0;
      br_valid = 1'b0; br_target = 32'd0; out_ready = 1'b0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_drop();
      test_branch_fault();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter IMEM_DEPTH, default 13, SHALL be the instruction memory word count; legal addresses are 0..IMEM_DEPTH-1.
REQ-002 Addresses SHALL be word indices: sequential PC increment is +1.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin fetching at start_pc.
REQ-006 start_pc  in  32  first fetch address.
REQ-007 imem_en  out  1  read enable to instruction memory.
REQ-008 imem_addr  out  32  read address to instruction memory.
REQ-009 imem_rdata  in  32  instruction word, combinational and valid in the same cycle as imem_addr.
REQ-010 br_valid  in  1  redirect request from execute.
REQ-011 br_target  in  32  redirect address.
REQ-012 out_valid  out  1  out_instr/out_pc hold a fetched instruction.
REQ-013 out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
REQ-014 out_instr  out  32  registered instruction.
REQ-015 out_pc  out  32  address of out_instr.
REQ-016 busy  out  1  high in FETCH and STALL, and in DONE/FAULT while out_valid=1.
REQ-017 done  out  1  high in DONE.
REQ-018 fault  out  1  high in FAULT.
REQ-019 xfer_count  out  16  accepted transfers since last start; wraps 0xFFFF->0.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, STALL, DONE, FAULT.
REQ-021 IDLE: imem_en=0; start -> pc<=start_pc, xfer_count<=0, go FETCH; other inputs ignored.
REQ-022 imem_en SHALL be 1 only in FETCH with pc < IMEM_DEPTH; imem_addr SHALL equal pc whenever imem_en=1, else 0.
REQ-023 FETCH, output slot free (out_valid=0 or transfer this cycle), pc < IMEM_DEPTH: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1; latency one cycle from imem_addr to out_valid.
REQ-024 FETCH, out_valid=1 and out_ready=0: no read, pc held, go STALL; out_instr/out_pc SHALL not change while out_valid=1 and not accepted.
REQ-025 STALL: on transfer, out_valid<=0 and return to FETCH; fetch resumes the following cycle (one bubble).
REQ-026 Sequential fetch with pc == IMEM_DEPTH: no read, go DONE.
REQ-027 Fetch with pc >= IMEM_DEPTH reached via start_pc or br_target: go FAULT.
REQ-028 br_valid in FETCH or STALL SHALL take priority over sequential fetch: pc<=br_target, out_valid<=0 next cycle, no read that cycle, go FETCH.
REQ-029 br_valid with a same-cycle transfer: transfer completes and counts; br_valid with out_valid=1 and out_ready=0: held instruction dropped, not counted.
REQ-030 br_valid SHALL be ignored in IDLE, DONE, FAULT.
REQ-031 DONE/FAULT: a pending out_valid SHALL drain normally (counted); no new reads.
REQ-032 start SHALL be ignored in FETCH and STALL; in DONE or FAULT it restarts per REQ-021 and clears done/fault next cycle, discarding any undrained output.
REQ-033 xfer_count SHALL increment by 1 on every transfer (out_valid && out_ready), in any state.

Reset
REQ-034 reset SHALL take priority over all inputs and force state IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, xfer_count=0, busy=0, done=0, fault=0, imem_en=0, imem_addr=0.
REQ-035 reset asserted mid-operation SHALL discard any held instruction; first fetch after reset requires a new start.

Verification
REQ-036 Memory word i = 0xE000_0000+i, out_ready=1, start with start_pc=0 -> out_instr 0xE0000000..0xE000000C on 13 consecutive cycles, out_pc 0..12, then done=1, busy=0, xfer_count=13.
REQ-037 start_pc=2, out_ready=0 for 3 cycles after first out_valid -> out_instr=0xE0000002 stable, imem_en=0 while held; on release 0xE0000003 follows after one bubble.
REQ-038 At out_pc=4 with out_ready=0 assert br_valid, br_target=10 -> instr 4 dropped, next out_pc=10, xfer_count excludes 4.
REQ-039 br_valid, br_target=20 -> fault=1, imem_en=0, no further out_valid; start with start_pc=0 -> fault clears, fetch resumes at 0.
REQ-040 reset asserted while out_valid=1 in STALL -> next cycle all outputs 0, state IDLE; start with start_pc=5 -> out_pc=5 one cycle after fetch.
